sched_rr: RTL and testbench

SCHED_RR -- requirements
Module: sched_rr

---
 rtl/sched_rr_if.sv | 42 ++++
 rtl/sched_rr.sv | 177 +++++++++++++++++
 tb/tb_sched_rr.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : sched_rr_if
// Description : Handshake and schedule bus for the round-robin VOQ scheduler.
//               The master side requests rounds and supplies VOQ-empty flags.
//               The slave side (the scheduler) returns busy, a one-cycle valid
//               pulse and the grant/egress schedule.
//   start        master->slave  one-cycle pulse requesting a round
//   voq_empty    master->slave  [4i+3:4i] = ingress i empty flags per egress
//   busy         slave->master  round in progress
//   sched_valid  slave->master  one-cycle pulse, schedule valid
//   sched_grant  slave->master  bit i = ingress i received an egress
//   sched_egress slave->master  [2i+1:2i] = egress granted to ingress i
// Revision    : 1.0 - initial release
// ============================================================================
interface sched_rr_if;
    logic        start;
    logic [15:0] voq_empty;
    logic        busy;
    logic        sched_valid;
    logic [3:0]  sched_grant;
    logic [7:0]  sched_egress;

    modport master (
        output start,
        output voq_empty,
        input  busy,
        input  sched_valid,
        input  sched_grant,
        input  sched_egress
    );

    modport slave (
        input  start,
        input  voq_empty,
        output busy,
        output sched_valid,
        output sched_grant,
        output sched_egress
    );
endinterface
`default_nettype wire

// File: rtl/sched_rr.sv
`default_nettype none
// ============================================================================
// Module      : sched_rr
// Description : 4x4 round-robin VOQ scheduler. A start pulse snapshots the
//               VOQ-empty flags, then four PICK cycles each service one
//               ingress (rotating start ingress per round). Each serviced
//               ingress takes the first free, non-empty egress searching from
//               its own rotating egress pointer. A one-cycle sched_valid pulse
//               follows; grant/egress results hold until the next round.
// Ports       : clk          - single clock, rising edge
//               reset        - asynchronous, active-high
//               bus          - sched_rr_if.slave (start, voq_empty, busy,
//                              sched_valid, sched_grant, sched_egress)
//               grant_count  - 16-bit saturating grant total
//                              (only when SCHED_STATS_EN is defined)
// Options     : `define SCHED_STATS_EN to add the grant_count statistic.
// Parameters  : NONE_IDX - egress index reported for ungranted ingresses
// Revision    : 1.0 - initial release
// ============================================================================
module sched_rr #(
    parameter logic [1:0] NONE_IDX = 2'd0
) (
    input  wire logic   clk,
    input  wire logic   reset,
    sched_rr_if.slave   bus
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] grant_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PICK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_step;
    logic [15:0] r_snap;
    logic [3:0]  r_taken;
    logic [3:0]  r_grant;
    logic [7:0]  r_egress;
    logic        r_valid;
    logic [1:0]  r_ing_ptr;
    logic [1:0]  r_egr_ptr [4];

    logic [1:0]  w_ing;
    logic [1:0]  w_base;
    logic [3:0]  w_row;
    logic [1:0]  w_cand;
    logic [1:0]  w_pick;
    logic        w_found;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_PICK;
            ST_PICK: if (r_step == 2'd3) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Egress search for the ingress serviced this PICK step
    // ------------------------------------------------------------------
    assign w_ing  = r_ing_ptr + r_step;
    assign w_base = r_egr_ptr[w_ing];
    assign w_row  = r_snap[{w_ing, 2'b00} +: 4];

    // Rotating first-fit: candidates visited in order base, base+1, ...
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_cand  = w_base;
        for (int j = 0; j < 4; j++) begin
            w_cand = w_base + 2'(j);
            if (!w_found && !w_row[w_cand] && !r_taken[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step    <= 2'd0;
            r_snap    <= 16'h0000;
            r_taken   <= 4'b0000;
            r_grant   <= 4'b0000;
            r_egress  <= {4{NONE_IDX}};
            r_valid   <= 1'b0;
            r_ing_ptr <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_egr_ptr[k] <= 2'd0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // Snapshot isolates the round from later VOQ changes.
                        r_snap   <= bus.voq_empty;
                        r_taken  <= 4'b0000;
                        r_grant  <= 4'b0000;
                        r_egress <= {4{NONE_IDX}};
                        r_step   <= 2'd0;
                    end
                end
                ST_PICK: begin
                    r_step <= r_step + 2'd1;
                    if (w_found) begin
                        r_taken[w_pick]              <= 1'b1;
                        r_grant[w_ing]               <= 1'b1;
                        r_egress[{w_ing, 1'b0} +: 2] <= w_pick;
                        r_egr_ptr[w_ing]             <= w_pick + 2'd1;
                    end else begin
                        r_egress[{w_ing, 1'b0} +: 2] <= NONE_IDX;
                    end
                end
                ST_DONE: begin
                    // Valid is registered so it lands the cycle after DONE.
                    r_valid   <= 1'b1;
                    r_ing_ptr <= r_ing_ptr + 2'd1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.sched_valid  = r_valid;
    assign bus.sched_grant  = r_grant;
    assign bus.sched_egress = r_egress;

`ifdef SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Saturating grant counter, updated alongside the valid pulse
    // ------------------------------------------------------------------
    logic [15:0] r_count;
    logic [2:0]  w_pop;
    logic [16:0] w_sum;

    assign w_pop = {2'b00, r_grant[0]} + {2'b00, r_grant[1]}
                 + {2'b00, r_grant[2]} + {2'b00, r_grant[3]};
    assign w_sum = {1'b0, r_count} + {14'd0, w_pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'h0000;
        end else if (r_state == ST_DONE) begin
            r_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign grant_count = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sched_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_sched_rr
// Description : Self-checking bench for sched_rr. A queue-free behavioural
//               model computes each round's schedule at the accepted start
//               and a compare process checks busy/valid every cycle and the
//               held schedule whenever the scheduler is idle. Directed rounds
//               pin known results, then randomized start/VOQ/reset traffic.
//               Define SCHED_STATS_EN to also check grant_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sched_rr;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sched_rr_if bus ();

`ifdef SCHED_STATS_EN
    logic [15:0] grant_count;
`endif

    sched_rr #(
        .NONE_IDX (2'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef SCHED_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int         m_cnt = 0;        // cycles since accepted start, 0 = idle
    bit         m_valid = 1'b0;
    bit [1:0]   m_ing_ptr = 2'd0;
    int         m_egr_ptr [4] = '{0, 0, 0, 0};
    bit [3:0]   m_grant = 4'b0, m_pend_grant = 4'b0;
    bit [7:0]   m_egress = 8'h00, m_pend_egress = 8'h00;
    int         m_stats = 0;

    function automatic void model_round(input logic [15:0] emp);
        bit [3:0] taken;
        taken         = 4'b0;
        m_pend_grant  = 4'b0;
        m_pend_egress = 8'h00;
        for (int k = 0; k < 4; k++) begin
            int  i;
            bit  got;
            i   = (int'(m_ing_ptr) + k) % 4;
            got = 1'b0;
            for (int j = 0; j < 4; j++) begin
                int e;
                e = (m_egr_ptr[i] + j) % 4;
                if (!got && emp[4*i+e] == 1'b0 && !taken[e]) begin
                    got                       = 1'b1;
                    taken[e]                  = 1'b1;
                    m_pend_grant[i]           = 1'b1;
                    m_pend_egress[2*i +: 2]   = 2'(e);
                    m_egr_ptr[i]              = (e + 1) % 4;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (reset) begin
            m_cnt     = 0;
            m_valid   = 1'b0;
            m_ing_ptr = 2'd0;
            for (int k = 0; k < 4; k++) m_egr_ptr[k] = 0;
            m_grant   = 4'b0;
            m_egress  = 8'h00;
            m_stats   = 0;
        end else begin
            m_valid = 1'b0;
            if (m_cnt == 5) begin
                m_cnt     = 0;
                m_valid   = 1'b1;
                m_grant   = m_pend_grant;
                m_egress  = m_pend_egress;
                m_ing_ptr = m_ing_ptr + 2'd1;
                m_stats   = m_stats + $countones(m_pend_grant);
                if (m_stats > 65535) m_stats = 65535;
            end else if (m_cnt != 0) begin
                m_cnt++;
            end else if (bus.start) begin
                model_round(bus.voq_empty);
                m_cnt = 1;
            end
        end
        check("busy", {31'b0, bus.busy}, {31'b0, (m_cnt != 0)});
        check("valid", {31'b0, bus.sched_valid}, {31'b0, m_valid});
        if (m_cnt == 0) begin
            check("grant", {28'b0, bus.sched_grant}, {28'b0, m_grant});
            check("egress", {24'b0, bus.sched_egress}, {24'b0, m_egress});
`ifdef SCHED_STATS_EN
            check("grant_count", {16'b0, grant_count}, 32'(m_stats));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Directed round: start with v, flip VOQ flags right after the start
    // edge, optionally re-pulse start at T+2; observe 12 cycles.
    // ------------------------------------------------------------------
    task automatic run_round(input logic [15:0] v, input bit extra_start,
                             output int lat, output int pulses);
        @(negedge clk);
        bus.voq_empty = v;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.voq_empty = ~v;
        lat    = -1;
        pulses = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.sched_valid) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (extra_start && c == 1) begin
                @(negedge clk);
                bus.start = 1'b1;
            end
            if (extra_start && c == 2) bus.start = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, pulses;
        bus.start     = 1'b0;
        bus.voq_empty = 16'h0000;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_valid", {31'b0, bus.sched_valid}, 32'd0);
        check("rst_grant", {28'b0, bus.sched_grant}, 32'd0);
        check("rst_egress", {24'b0, bus.sched_egress}, 32'd0);

        // First round after reset, with an ignored start at T+2.
        run_round(16'h0000, 1'b1, lat, pulses);
        check("r1_latency", 32'(lat), 32'd5);
        check("r1_pulses", 32'(pulses), 32'd1);
        check("r1_grant", {28'b0, bus.sched_grant}, 32'h0000000F);
        check("r1_egress", {24'b0, bus.sched_egress}, 32'h000000E4);
`ifdef SCHED_STATS_EN
        check("r1_count", {16'b0, grant_count}, 32'd4);
`endif

        // Second identical round: rotated ingress and egress pointers.
        run_round(16'h0000, 1'b0, lat, pulses);
        check("r2_latency", 32'(lat), 32'd5);
        check("r2_grant", {28'b0, bus.sched_grant}, 32'h0000000F);
        check("r2_egress", {24'b0, bus.sched_egress}, 32'h00000039);

        // Only egress 2 non-empty: ingress 2 is serviced first.
        run_round(16'hBBBB, 1'b0, lat, pulses);
        check("r3_grant", {28'b0, bus.sched_grant}, 32'h00000004);
        check("r3_egress", {24'b0, bus.sched_egress}, 32'h00000020);

        // All empty: round still completes with no grants.
        run_round(16'hFFFF, 1'b0, lat, pulses);
        check("r4_latency", 32'(lat), 32'd5);
        check("r4_grant", {28'b0, bus.sched_grant}, 32'd0);
        check("r4_egress", {24'b0, bus.sched_egress}, 32'd0);
`ifdef SCHED_STATS_EN
        check("r4_count", {16'b0, grant_count}, 32'd9);
`endif

        // Reset during PICK step 2.
        @(negedge clk);
        bus.voq_empty = 16'h0000;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_valid", {31'b0, bus.sched_valid}, 32'd0);
        check("mid_rst_grant", {28'b0, bus.sched_grant}, 32'd0);
        check("mid_rst_egress", {24'b0, bus.sched_egress}, 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.sched_valid) pulses++;
        end
        check("mid_rst_no_valid", 32'(pulses), 32'd0);
        run_round(16'h0000, 1'b0, lat, pulses);
        check("r5_latency", 32'(lat), 32'd5);
        check("r5_grant", {28'b0, bus.sched_grant}, 32'h0000000F);
        check("r5_egress", {24'b0, bus.sched_egress}, 32'h000000E4);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 2))
                0:       bus.voq_empty = 16'($urandom & $urandom);
                1:       bus.voq_empty = 16'($urandom | $urandom);
                default: bus.voq_empty = 16'($urandom);
            endcase
            bus.start = ($urandom_range(0, 2) == 0);
            reset     = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
